riscv_hwloop_sequencer: RTL and testbench
=========================================

# riscv_hwloop_sequencer

Hardware-loop sequencer between the ID stage, the hardware-loop register file and the prefetch unit. It compares the PC of each retiring ID-stage instruction against all loop end addresses and selects one loop by fixed priority. It pulses that loop's counter-decrement line and, when iterations remain, issues a held jump request to the loop start address. ID is stalled until the fetch side accepts the request or a flush cancels it.

## Interface
- N_REGS, 2, number of hardware loops; index 0 is the innermost loop and has the highest priority
- N_REG_BITS, $clog2(N_REGS), loop index width
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- pc_id_i  in  32  PC of the instruction currently in ID
- id_valid_i  in  1  ID instruction retires this cycle; same signal drives valid_i of the loop registers
- flush_i  in  1  branch, exception or debug kill; cancels any match or pending jump
- hwlp_start_addr_i  in  N_REGS x 32  loop start addresses
- hwlp_end_addr_i  in  N_REGS x 32  loop end addresses (address of the last loop-body instruction)
- hwlp_counter_i  in  N_REGS x 32  remaining iterations; 0 means the loop is inactive
- hwlp_dec_cnt_o  out  N_REGS  one-hot decrement strobe to the loop registers
- jump_req_o  out  1  jump request to the prefetch unit
- jump_target_o  out  32  jump destination; stable while jump_req_o is high
- jump_ack_i  in  1  prefetch unit accepts the jump
- stall_id_o  out  1  hold ID; no instruction may retire while high
- active_loop_o  out  N_REG_BITS  index of the loop that caused the pending jump

## Operation
- Per loop k: hit[k] = (pc_id_i == hwlp_end_addr_i[k]) && (hwlp_counter_i[k] != 0).
- sel = lowest k with hit[k]; any_hit = OR of hit.
- more = |hwlp_counter_i[sel][31:1], i.e. counter >= 2.
- FSM states:
  - IDLE:
    - Qualified event is id_valid_i && !flush_i && any_hit.
    - On a qualified event, hwlp_dec_cnt_o[sel] = 1 (combinational, same cycle).
    - If more is also set: register jump_target_o <= hwlp_start_addr_i[sel] and active_loop_o <= sel, then go to REQ.
    - If counter == 1: decrement only; the instruction falls through and the FSM stays in IDLE.
  - REQ:
    - jump_req_o = 1 and stall_id_o = 1; hwlp_dec_cnt_o is forced to 0.
    - jump_ack_i leads to IDLE.
    - flush_i leads to IDLE; flush has priority over a simultaneous ack, and the request is dropped.
- At most one bit of hwlp_dec_cnt_o is ever set; a second loop with the same end address is not decremented in that cycle.
- Nested loops sharing an end address fall through to the outer loop only on a later pass. Software places distinct end addresses when this matters.
- Counter arithmetic stays in the register file; this block only compares, treating values as 32-bit unsigned.

## Timing
- Reset values:
  - State IDLE.
  - jump_req_o = 0, stall_id_o = 0, hwlp_dec_cnt_o = 0.
  - jump_target_o = 32'h0, active_loop_o = 0, perf_jump_cnt_o = 0.
- Decrement strobe has 0-cycle latency: it is valid in the same cycle as id_valid_i, and the registers update at that edge.
- jump_req_o rises 1 cycle after the end-instruction retires.
- Minimum REQ duration is 1 cycle, when jump_ack_i is already high; REQ holds indefinitely otherwise.
- The ack is sampled only while jump_req_o is high. The earliest new match is the cycle after leaving REQ.
- Counter values sampled in IDLE are pre-decrement, so the decision uses the value before the update.
- Register writes (lp.setup) landing in the same cycle as a match are not visible until the next cycle.
- Reset asserted mid-REQ drops the request asynchronously, with no ack required.

## Configuration
- HWLOOP_PERF_EN defined:
  - Adds output perf_jump_cnt_o [31:0].
  - The counter increments on each IDLE to REQ transition, including ones later flushed.
  - It saturates at 32'hFFFF_FFFF and resets to 0.
- HWLOOP_PERF_EN undefined: the port and counter are absent and there are no other differences.

## Test plan
- Single loop: start=0x100, end=0x10C, cnt=3; retire at 0x10C three times.
  - First two retires: dec[0] pulse, jump_target_o=0x100, 1-cycle REQ with immediate ack.
  - Third retire (cnt=1): dec only, no jump_req_o.
- Priority: loop0 end=0x200 cnt=2, loop1 end=0x200 cnt=5, retire 0x200.
  - Expected: dec=2'b01, active_loop_o=0, target=loop0 start.
  - Loop1 counter stays 5.
- Delayed ack: hold jump_ack_i low 4 cycles.
  - jump_req_o and stall_id_o stay high 4 cycles with target stable.
  - Retires forced by the bench during REQ produce no dec pulse.
- Flush: flush_i together with a match gives no dec and no req. flush_i plus ack in REQ returns to IDLE with jump_req_o=0 the next cycle.
- Inactive and non-matching cases: cnt=0 at end address, or a PC of 0x104 not equal to end, give no outputs. Assert rst_n mid-REQ: all outputs 0 immediately.
- HWLOOP_PERF_EN: 3 taken jumps give perf_jump_cnt_o=3. Preload the counter near its maximum and confirm it saturates at 0xFFFF_FFFF.

Source files
------------

// File: rtl/riscv_hwloop_sequencer.sv
// riscv_hwloop_sequencer
// Hardware-loop sequencer between ID, the hardware-loop register file and
// the prefetch unit. Matches the retiring ID-stage PC against every loop end
// address, picks the innermost active loop, strobes its decrement line and,
// when further iterations remain, raises a held jump request to the loop
// start address while stalling ID.
// Optional feature macro: HWLOOP_PERF_EN adds perf_jump_cnt_o, a saturating
// count of issued jump requests.
module riscv_hwloop_sequencer #(
  parameter int unsigned N_REGS     = 2,
  parameter int unsigned N_REG_BITS = $clog2(N_REGS)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [31:0]                 pc_id_i,
  input  logic                        id_valid_i,
  input  logic                        flush_i,
  input  logic [N_REGS-1:0][31:0]     hwlp_start_addr_i,
  input  logic [N_REGS-1:0][31:0]     hwlp_end_addr_i,
  input  logic [N_REGS-1:0][31:0]     hwlp_counter_i,
  output logic [N_REGS-1:0]           hwlp_dec_cnt_o,
  output logic                        jump_req_o,
  output logic [31:0]                 jump_target_o,
  input  logic                        jump_ack_i,
  output logic                        stall_id_o,
  output logic [N_REG_BITS-1:0]       active_loop_o
`ifdef HWLOOP_PERF_EN
  ,
  output logic [31:0]                 perf_jump_cnt_o
`endif
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] REQ  = 1'b1;

  logic [0:0]            state_q;
  logic [N_REGS-1:0]     hit;
  logic                  any_hit;
  logic [N_REG_BITS-1:0] sel;
  logic                  more;
  logic                  match_evt;

  // End-address compare per loop and fixed-priority selection (index 0 wins)
  always_comb begin
    hit     = '0;
    any_hit = 1'b0;
    sel     = '0;
    for (int unsigned k = 0; k < N_REGS; k++) begin
      hit[k] = (pc_id_i == hwlp_end_addr_i[k]) && (hwlp_counter_i[k] != 32'h0);
    end
    for (int unsigned k = N_REGS; k > 0; k--) begin
      if (hit[k-1]) begin
        sel     = N_REG_BITS'(k-1);
        any_hit = 1'b1;
      end
    end
  end

  // Qualified match, remaining-iteration test and the one-hot decrement strobe
  always_comb begin
    more           = |hwlp_counter_i[sel][31:1];
    match_evt      = (state_q == IDLE) && id_valid_i && !flush_i && any_hit;
    hwlp_dec_cnt_o = '0;
    if (match_evt) begin
      hwlp_dec_cnt_o[sel] = 1'b1;
    end
  end

  assign jump_req_o = (state_q == REQ);
  assign stall_id_o = (state_q == REQ);

  // Sequencer state with latched jump target and loop index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      jump_target_o <= 32'h0;
      active_loop_o <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (match_evt && more) begin
            jump_target_o <= hwlp_start_addr_i[sel];
            active_loop_o <= sel;
            state_q       <= REQ;
          end
        end
        REQ: begin
          // flush and ack both return to IDLE; a flush drops the request
          if (flush_i || jump_ack_i) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef HWLOOP_PERF_EN
  // Saturating count of IDLE-to-REQ transitions, flushed ones included
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_jump_cnt_o <= 32'h0;
    end else if (match_evt && more && (perf_jump_cnt_o != 32'hFFFF_FFFF)) begin
      perf_jump_cnt_o <= perf_jump_cnt_o + 32'h1;
    end
  end
`endif

endmodule

// File: tb/tb_riscv_hwloop_sequencer.sv
// Directed testbench for riscv_hwloop_sequencer with a queue scoreboard.
module tb_riscv_hwloop_sequencer;

  logic              clk;
  logic              rst_n;
  logic [31:0]       pc_id;
  logic              id_valid;
  logic              flush;
  logic [1:0][31:0]  start_a;
  logic [1:0][31:0]  end_a;
  logic [1:0][31:0]  cnt;
  logic [1:0]        dec;
  logic              jreq;
  logic [31:0]       jtgt;
  logic              jack;
  logic              stall;
  logic [0:0]        act;
`ifdef HWLOOP_PERF_EN
  logic [31:0]       perf;
  logic [31:0]       perf_exp;
`endif

  riscv_hwloop_sequencer #(.N_REGS(2)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .pc_id_i           (pc_id),
    .id_valid_i        (id_valid),
    .flush_i           (flush),
    .hwlp_start_addr_i (start_a),
    .hwlp_end_addr_i   (end_a),
    .hwlp_counter_i    (cnt),
    .hwlp_dec_cnt_o    (dec),
    .jump_req_o        (jreq),
    .jump_target_o     (jtgt),
    .jump_ack_i        (jack),
    .stall_id_o        (stall),
    .active_loop_o     (act)
`ifdef HWLOOP_PERF_EN
    ,
    .perf_jump_cnt_o   (perf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] v;
  } exp_t;

  exp_t sb[$];
  int   n_cmp;
  int   n_mis;

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.v   = v;
    sb.push_back(e);
  endtask

  task automatic chk(input logic [31:0] obs);
    exp_t e;
    n_cmp++;
    if (sb.size() == 0) begin
      n_mis++;
      $error("FAIL scoreboard_empty observed=%h expected=<entry>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.v) else begin
        n_mis++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.v);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one retiring instruction; check the same-cycle strobe, then the
  // registered request and target/index one cycle later.
  task automatic retire(input logic [31:0] pc, input logic fl,
                        input logic [1:0] e_dec, input logic e_req,
                        input logic [31:0] e_tgt, input logic [0:0] e_act);
    pc_id    = pc;
    id_valid = 1'b1;
    flush    = fl;
    push("dec_strobe", {30'h0, e_dec});
    push("jump_req_next", {31'h0, e_req});
    push("stall_next", {31'h0, e_req});
    if (e_req) begin
      push("jump_target", e_tgt);
      push("active_loop", {31'h0, e_act});
`ifdef HWLOOP_PERF_EN
      if (perf_exp != 32'hFFFF_FFFF) perf_exp++;
`endif
    end
    #1;
    chk({30'h0, dec});
    tick();
    id_valid = 1'b0;
    flush    = 1'b0;
    #1;
    chk({31'h0, jreq});
    chk({31'h0, stall});
    if (e_req) begin
      chk(jtgt);
      chk({31'h0, act});
    end
  endtask

  // One cycle in REQ: expect request held before the edge, state after it
  task automatic req_cycle(input string tag, input logic e_after);
    push({tag, "_req_held"}, 32'h1);
    chk({31'h0, jreq});
    tick();
    #1;
    push({tag, "_req_after"}, {31'h0, e_after});
    chk({31'h0, jreq});
  endtask

  initial begin
    n_cmp    = 0;
    n_mis    = 0;
    rst_n    = 1'b0;
    pc_id    = 32'h0;
    id_valid = 1'b0;
    flush    = 1'b0;
    jack     = 1'b0;
    start_a  = '0;
    end_a    = '0;
    cnt      = '0;
`ifdef HWLOOP_PERF_EN
    perf_exp = 32'h0;
`endif
    #2;
    push("rst_req", 32'h0);    chk({31'h0, jreq});
    push("rst_stall", 32'h0);  chk({31'h0, stall});
    push("rst_dec", 32'h0);    chk({30'h0, dec});
    push("rst_target", 32'h0); chk(jtgt);
    push("rst_active", 32'h0); chk({31'h0, act});
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Single loop, three passes, immediate ack
    start_a[0] = 32'h100; end_a[0] = 32'h10C; cnt[0] = 32'd3;
    end_a[1]   = 32'hFFFF_0000; cnt[1] = 32'd0;
    jack = 1'b1;
    retire(32'h10C, 1'b0, 2'b01, 1'b1, 32'h100, 1'b0);
    cnt[0] = 32'd2;
    req_cycle("single_p1", 1'b0);
    retire(32'h10C, 1'b0, 2'b01, 1'b1, 32'h100, 1'b0);
    cnt[0] = 32'd1;
    req_cycle("single_p2", 1'b0);
    retire(32'h10C, 1'b0, 2'b01, 1'b0, 32'h0, 1'b0);
    cnt[0] = 32'd0;

    // Priority: both loops share an end address, loop 0 wins
    start_a[0] = 32'h180; end_a[0] = 32'h200; cnt[0] = 32'd2;
    start_a[1] = 32'h1F0; end_a[1] = 32'h200; cnt[1] = 32'd5;
    retire(32'h200, 1'b0, 2'b01, 1'b1, 32'h180, 1'b0);
    cnt[0] = 32'd1;
    req_cycle("prio", 1'b0);

    // Delayed ack through loop 1, with retires forced during REQ
    cnt[0] = 32'd0;
    jack   = 1'b0;
    retire(32'h200, 1'b0, 2'b10, 1'b1, 32'h1F0, 1'b1);
    cnt[1] = 32'd4;
    for (int i = 0; i < 4; i++) begin
      pc_id    = 32'h200;
      id_valid = 1'b1;
      #1;
      push("hold_dec", 32'h0);    chk({30'h0, dec});
      push("hold_stall", 32'h1);  chk({31'h0, stall});
      push("hold_target", 32'h1F0); chk(jtgt);
      req_cycle("hold", 1'b1);
    end
    id_valid = 1'b0;
    jack     = 1'b1;
    req_cycle("late_ack", 1'b0);

    // Flush with a match: nothing happens
    retire(32'h200, 1'b1, 2'b00, 1'b0, 32'h0, 1'b0);
    // Flush together with ack while in REQ
    jack = 1'b0;
    retire(32'h200, 1'b0, 2'b10, 1'b1, 32'h1F0, 1'b1);
    cnt[1] = 32'd3;
    flush = 1'b1;
    jack  = 1'b1;
    req_cycle("flush_ack", 1'b0);
    flush = 1'b0;
    push("flush_stall", 32'h0); chk({31'h0, stall});

    // Inactive loops at the end address, and a non-end PC
    cnt = '0;
    retire(32'h200, 1'b0, 2'b00, 1'b0, 32'h0, 1'b0);
    start_a[0] = 32'h100; end_a[0] = 32'h10C; cnt[0] = 32'd3;
    retire(32'h104, 1'b0, 2'b00, 1'b0, 32'h0, 1'b0);

`ifdef HWLOOP_PERF_EN
    push("perf_count", perf_exp); chk(perf);
`endif

    // Reset asserted mid-REQ drops everything immediately
    jack = 1'b0;
    retire(32'h10C, 1'b0, 2'b01, 1'b1, 32'h100, 1'b0);
    cnt[0] = 32'd2;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    push("midrst_req", 32'h0);    chk({31'h0, jreq});
    push("midrst_stall", 32'h0);  chk({31'h0, stall});
    push("midrst_target", 32'h0); chk(jtgt);
    push("midrst_dec", 32'h0);    chk({30'h0, dec});
`ifdef HWLOOP_PERF_EN
    push("midrst_perf", 32'h0);   chk(perf);
    perf_exp = 32'hFFFF_FFFF;
`endif
    @(negedge clk);
    rst_n = 1'b1;
    tick();

`ifdef HWLOOP_PERF_EN
    force dut.perf_jump_cnt_o = 32'hFFFF_FFFF;
    #1;
    release dut.perf_jump_cnt_o;
    jack = 1'b1;
    retire(32'h10C, 1'b0, 2'b01, 1'b1, 32'h100, 1'b0);
    tick();
    push("perf_saturate", 32'hFFFF_FFFF); chk(perf);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
